imem_arbiter: RTL and testbench

//  Shares one single-port synchronous instruction memory between two requesters:
//  the CPU fetch stage (read-only) and the debug/program loader (read/write).
//  It sits between the IF stage, the debug unit and the imem array.

---
 rtl/imem_arbiter_if.sv | 45 ++++
 rtl/imem_arbiter.sv | 115 +++++++++++
 tb/tb_imem_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters and the imem array.
// The arbiter uses the slave modport; requesters and memory sit on the master side.
interface imem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  if_req;
    logic [31:0]           if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [31:0]           if_rdata;
    logic                  if_misalign;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [31:0]           dbg_addr;
    logic [31:0]           dbg_wdata;
    logic                  dbg_lock;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;
    logic [31:0]           dbg_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-3:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_misalign,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_misalign,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Shares a single-port synchronous instruction memory between the fetch stage and the debug
// loader: combinational grant, starvation limit, debug lock, 1-cycle tagged read return.
module imem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned MAX_HOLD   = 4,
    parameter bit          DBG_PRIO   = 1'b1
) (
    input logic           clk,
    input logic           rst,
    imem_arbiter_if.slave bus
);
    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

    typedef enum logic {StArb, StLocked} state_e;
    typedef enum logic [1:0] {TagNone, TagFetch, TagDebug, TagMisalign} tag_e;

    state_e           state_q, state_d;
    tag_e             tag_q, tag_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             last_dbg_q, last_dbg_d;  // last_winner: 0 = fetch, 1 = debug
    logic             gnt_if, gnt_dbg, both, aligned;
    logic             unused_addr;

    assign both    = bus.if_req & bus.dbg_req;
    assign aligned = (bus.if_addr[1:0] == 2'b00);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        last_dbg_d = last_dbg_q;
        gnt_if     = 1'b0;
        gnt_dbg    = 1'b0;
        case (state_q)
            StArb: begin
                if (both) begin
                    if (hold_q == HoldMax) begin
                        gnt_dbg = ~last_dbg_q;
                    end else if (DBG_PRIO) begin
                        gnt_dbg = 1'b1;
                    end else begin
                        gnt_dbg = ~last_dbg_q;
                    end
                    gnt_if = ~gnt_dbg;
                end else begin
                    gnt_if  = bus.if_req;
                    gnt_dbg = bus.dbg_req;
                end
                // Count only while the loser is actually waiting.
                if (!both) begin
                    hold_d = '0;
                end else if (gnt_dbg != last_dbg_q) begin
                    hold_d = HoldW'(1);
                end else if (hold_q != HoldMax) begin
                    hold_d = hold_q + 1'b1;
                end
                if (bus.dbg_lock) begin
                    state_d = StLocked;
                end
            end
            StLocked: begin
                gnt_dbg = bus.dbg_req;
                hold_d  = '0;
                if (!bus.dbg_lock) begin
                    state_d = StArb;
                end
            end
            default: state_d = StArb;
        endcase
        if (gnt_if | gnt_dbg) begin
            last_dbg_d = gnt_dbg;
        end
    end

    always_comb begin
        tag_d = TagNone;
        if (gnt_if) begin
            tag_d = aligned ? TagFetch : TagMisalign;
        end else if (gnt_dbg && !bus.dbg_we) begin
            tag_d = TagDebug;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StArb;
            tag_q      <= TagNone;
            hold_q     <= '0;
            last_dbg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            hold_q     <= hold_d;
            last_dbg_q <= last_dbg_d;
        end
    end

    assign bus.if_gnt    = gnt_if;
    assign bus.dbg_gnt   = gnt_dbg;
    assign bus.mem_en    = gnt_dbg | (gnt_if & aligned);
    assign bus.mem_we    = gnt_dbg & bus.dbg_we;
    assign bus.mem_addr  = gnt_dbg ? bus.dbg_addr[ADDR_WIDTH-1:2] :
                           gnt_if  ? bus.if_addr[ADDR_WIDTH-1:2]  : '0;
    assign bus.mem_wdata = gnt_dbg ? bus.dbg_wdata : '0;

    // A misaligned fetch never touched memory, so it returns zero data.
    assign bus.if_rvalid   = (tag_q == TagFetch) || (tag_q == TagMisalign);
    assign bus.if_misalign = (tag_q == TagMisalign);
    assign bus.if_rdata    = (tag_q == TagFetch) ? bus.mem_rdata : '0;
    assign bus.dbg_rvalid  = (tag_q == TagDebug);
    assign bus.dbg_rdata   = (tag_q == TagDebug) ? bus.mem_rdata : '0;

    assign unused_addr = ^{bus.if_addr[31:ADDR_WIDTH], bus.dbg_addr[31:ADDR_WIDTH],
                           bus.dbg_addr[1:0]};
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: one debug-priority and one round-robin instance, each with
// its own behavioural memory.
module tb_imem_arbiter;
    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        dlock;
        logic        igt;
        logic        dgt;
        logic        men;
        logic        mwe;
        logic [9:0]  maddr;
        logic        ivld;
        logic        imis;
        logic [31:0] irdata;
        logic        dvld;
        logic [31:0] drdata;
    } vec_t;

    localparam logic [31:0] Z  = 32'h0;
    localparam logic [31:0] FA = 32'h0000_0010;  // fetch address, word 4
    localparam logic [31:0] DA = 32'h0000_0020;  // debug address, word 8
    localparam logic [31:0] P1 = 32'hA500_0001;
    localparam logic [31:0] P4 = 32'hA500_0004;
    localparam logic [31:0] P8 = 32'hA500_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [31:0] if_addr = '0, dbg_addr = '0, dbg_wdata = '0;
    logic [31:0] mem_p [1024];
    logic [31:0] mem_r [1024];
    logic [31:0] rdata_p, rdata_r;
    int          errors = 0;
    int          checks = 0;
    vec_t        tbl [25];

    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_WIDTH(12)) bus_p ();
    imem_arbiter_if #(.ADDR_WIDTH(12)) bus_r ();

    assign bus_p.if_req    = if_req;
    assign bus_p.if_addr   = if_addr;
    assign bus_p.dbg_req   = dbg_req;
    assign bus_p.dbg_we    = dbg_we;
    assign bus_p.dbg_addr  = dbg_addr;
    assign bus_p.dbg_wdata = dbg_wdata;
    assign bus_p.dbg_lock  = dbg_lock;
    assign bus_p.mem_rdata = rdata_p;
    assign bus_r.if_req    = if_req;
    assign bus_r.if_addr   = if_addr;
    assign bus_r.dbg_req   = dbg_req;
    assign bus_r.dbg_we    = dbg_we;
    assign bus_r.dbg_addr  = dbg_addr;
    assign bus_r.dbg_wdata = dbg_wdata;
    assign bus_r.dbg_lock  = dbg_lock;
    assign bus_r.mem_rdata = rdata_r;

    imem_arbiter #(.ADDR_WIDTH(12), .MAX_HOLD(4), .DBG_PRIO(1'b1)) u_prio (
        .clk (clk),
        .rst (rst),
        .bus (bus_p)
    );

    imem_arbiter #(.ADDR_WIDTH(12), .MAX_HOLD(4), .DBG_PRIO(1'b0)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_r)
    );

    function automatic logic [31:0] pat(input int i);
        return (i == 0) ? 32'h0000_0013 : (32'hA500_0000 | 32'(i));
    endfunction

    // Memories reload their pattern while reset is held.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 1024; i++) mem_p[i] <= pat(i);
            rdata_p <= '0;
        end else if (bus_p.mem_en) begin
            if (bus_p.mem_we) mem_p[bus_p.mem_addr] <= bus_p.mem_wdata;
            else rdata_p <= mem_p[bus_p.mem_addr];
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 1024; i++) mem_r[i] <= pat(i);
            rdata_r <= '0;
        end else if (bus_r.mem_en) begin
            if (bus_r.mem_we) mem_r[bus_r.mem_addr] <= bus_r.mem_wdata;
            else rdata_r <= mem_r[bus_r.mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if_req    = v.ireq;
        if_addr   = v.iaddr;
        dbg_req   = v.dreq;
        dbg_we    = v.dwe;
        dbg_addr  = v.daddr;
        dbg_wdata = v.dwdata;
        dbg_lock  = v.dlock;
    endtask

    task automatic apply_row(input int idx);
        vec_t v;
        v = tbl[idx];
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        chk($sformatf("row%0d if_gnt", idx), 32'(bus_p.if_gnt), 32'(v.igt));
        chk($sformatf("row%0d dbg_gnt", idx), 32'(bus_p.dbg_gnt), 32'(v.dgt));
        chk($sformatf("row%0d mem_en", idx), 32'(bus_p.mem_en), 32'(v.men));
        chk($sformatf("row%0d mem_we", idx), 32'(bus_p.mem_we), 32'(v.mwe));
        chk($sformatf("row%0d mem_addr", idx), 32'(bus_p.mem_addr), 32'(v.maddr));
        chk($sformatf("row%0d if_rvalid", idx), 32'(bus_p.if_rvalid), 32'(v.ivld));
        chk($sformatf("row%0d if_misalign", idx), 32'(bus_p.if_misalign), 32'(v.imis));
        chk($sformatf("row%0d if_rdata", idx), bus_p.if_rdata, v.irdata);
        chk($sformatf("row%0d dbg_rvalid", idx), 32'(bus_p.dbg_rvalid), 32'(v.dvld));
        chk($sformatf("row%0d dbg_rdata", idx), bus_p.dbg_rdata, v.drdata);
    endtask

    initial begin
        vec_t both_rd;
        vec_t lk_wr;

        // ireq iaddr dreq dwe daddr dwdata dlock | igt dgt men mwe maddr ivld imis irdata dvld drdata
        both_rd = '{'1, FA, '1, '0, DA, Z, '0, '0, '1, '1, '0, 10'd8, '0, '0, Z, '1, P8};
        tbl[0]  = '{'0, Z, '0, '0, Z, Z, '0, '0, '0, '0, '0, 10'd0, '1, '0, 32'h13, '0, Z};
        tbl[1]  = '{'1, FA, '1, '0, DA, Z, '0, '0, '1, '1, '0, 10'd8, '0, '0, Z, '0, Z};
        tbl[2]  = both_rd;
        tbl[3]  = both_rd;
        tbl[4]  = both_rd;
        tbl[5]  = '{'1, FA, '1, '0, DA, Z, '0, '1, '0, '1, '0, 10'd4, '0, '0, Z, '1, P8};
        tbl[6]  = '{'1, FA, '1, '0, DA, Z, '0, '0, '1, '1, '0, 10'd8, '1, '0, P4, '0, Z};
        tbl[7]  = both_rd;
        tbl[8]  = both_rd;
        tbl[9]  = both_rd;
        tbl[10] = tbl[5];
        tbl[11] = '{'0, Z, '0, '0, Z, Z, '0, '0, '0, '0, '0, 10'd0, '1, '0, P4, '0, Z};
        tbl[12] = '{'1, 32'h6, '0, '0, Z, Z, '0, '1, '0, '0, '0, 10'd1, '0, '0, Z, '0, Z};
        tbl[13] = '{'0, Z, '0, '0, Z, Z, '0, '0, '0, '0, '0, 10'd0, '1, '1, Z, '0, Z};
        tbl[14] = '{'0, Z, '1, '0, 32'h1004, Z, '0, '0, '1, '1, '0, 10'd1, '0, '0, Z, '0, Z};
        tbl[15] = '{'0, Z, '0, '0, Z, Z, '0, '0, '0, '0, '0, 10'd0, '0, '0, Z, '1, P1};
        tbl[16] = '{'1, FA, '0, '0, Z, Z, '1, '1, '0, '1, '0, 10'd4, '0, '0, Z, '0, Z};
        lk_wr   = '{'1, Z, '1, '1, Z, 32'hDEAD_0000, '1, '0, '1, '1, '1, 10'd0, '1, '0, P4, '0, Z};
        tbl[17] = lk_wr;
        lk_wr.daddr = 32'h4; lk_wr.dwdata = 32'hDEAD_0001; lk_wr.maddr = 10'd1;
        lk_wr.ivld = '0; lk_wr.irdata = Z;
        tbl[18] = lk_wr;
        lk_wr.daddr = 32'h8; lk_wr.dwdata = 32'hDEAD_0002; lk_wr.maddr = 10'd2;
        tbl[19] = lk_wr;
        tbl[20] = '{'1, Z, '0, '0, Z, Z, '0, '0, '0, '0, '0, 10'd0, '0, '0, Z, '0, Z};
        tbl[21] = '{'1, Z, '0, '0, Z, Z, '0, '1, '0, '1, '0, 10'd0, '0, '0, Z, '0, Z};
        tbl[22] = '{'1, 32'h4, '0, '0, Z, Z, '0, '1, '0, '1, '0, 10'd1, '1, '0, 32'hDEAD_0000,
                    '0, Z};
        tbl[23] = '{'1, 32'h8, '0, '0, Z, Z, '0, '1, '0, '1, '0, 10'd2, '1, '0, 32'hDEAD_0001,
                    '0, Z};
        tbl[24] = '{'0, Z, '0, '0, Z, Z, '0, '0, '0, '0, '0, 10'd0, '1, '0, 32'hDEAD_0002,
                    '0, Z};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset if_rvalid", 32'(bus_p.if_rvalid), 32'd0);
        chk("reset dbg_rvalid", 32'(bus_p.dbg_rvalid), 32'd0);
        chk("reset if_misalign", 32'(bus_p.if_misalign), 32'd0);
        chk("reset if_gnt", 32'(bus_p.if_gnt), 32'd0);
        chk("reset dbg_gnt", 32'(bus_p.dbg_gnt), 32'd0);
        chk("reset mem_en", 32'(bus_p.mem_en), 32'd0);
        chk("reset rr mem_en", 32'(bus_r.mem_en), 32'd0);

        // Read in flight when reset hits must never return.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 if_req = 1'b1; if_addr = Z;
        @(negedge clk);
        chk("pre-reset if_gnt", 32'(bus_p.if_gnt), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("reset drops if_rvalid", 32'(bus_p.if_rvalid), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("post-reset if_gnt", 32'(bus_p.if_gnt), 32'd1);
        chk("post-reset no stale rvalid", 32'(bus_p.if_rvalid), 32'd0);
        @(negedge clk);
        chk("first fetch if_rvalid", 32'(bus_p.if_rvalid), 32'd1);
        chk("first fetch if_rdata", bus_p.if_rdata, 32'h0000_0013);

        for (int i = 0; i < 25; i++) apply_row(i);

        // Round-robin instance: fresh reset, then strict alternation starting with debug.
        @(posedge clk); #1 rst = 1'b0; drive(tbl[0]);
        @(negedge clk);
        chk("rr reset dbg_rvalid", 32'(bus_r.dbg_rvalid), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic exp_d;
            exp_d = (i % 2 == 0);
            @(posedge clk); #1 drive(tbl[1]);
            @(negedge clk);
            chk($sformatf("rr%0d dbg_gnt", i), 32'(bus_r.dbg_gnt), 32'(exp_d));
            chk($sformatf("rr%0d if_gnt", i), 32'(bus_r.if_gnt), 32'(!exp_d));
            chk($sformatf("rr%0d mem_addr", i), 32'(bus_r.mem_addr), exp_d ? 32'd8 : 32'd4);
            if (i > 0) begin
                chk($sformatf("rr%0d dbg_rvalid", i), 32'(bus_r.dbg_rvalid), 32'(!exp_d));
                chk($sformatf("rr%0d if_rvalid", i), 32'(bus_r.if_rvalid), 32'(exp_d));
                chk($sformatf("rr%0d dbg_rdata", i), bus_r.dbg_rdata, exp_d ? Z : P8);
                chk($sformatf("rr%0d if_rdata", i), bus_r.if_rdata, exp_d ? P4 : Z);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
